// File: rtl/mbus_pwr_seq_multi.sv
// Multi-domain power sequencer: per-domain power-up/power-down walk plus sticky bus override mux.
// Latency: one control changes per step, steps spaced STEP_DLY+1 negedges; override mux is combinational.
// Backpressure: none; requests are level-sampled only in OFF/RUN, transient sequences always run to completion.

`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif
`ifndef IO_RELEASE
`define IO_RELEASE 1'b0
`endif

module mbus_pwr_seq_multi #(
  parameter int NUM_DOM = 2,
  parameter int DLY_W   = 4
) (
  input  logic               CLK_EXT,
  input  logic               RESETn_local,
  input  logic [DLY_W-1:0]   STEP_DLY,
  input  logic [NUM_DOM-1:0] WAKEUP_REQ,
  input  logic [NUM_DOM-1:0] SLEEP_REQ,
  input  logic [NUM_DOM-1:0] BUS_PWR_OVERRIDE,
  input  logic [NUM_DOM-1:0] POWER_ON_FROM_BUS,
  input  logic [NUM_DOM-1:0] RELEASE_CLK_FROM_BUS,
  input  logic [NUM_DOM-1:0] RELEASE_ISO_FROM_BUS,
  input  logic [NUM_DOM-1:0] RELEASE_RST_FROM_BUS,
  output logic [NUM_DOM-1:0] POWER_ON,
  output logic [NUM_DOM-1:0] RELEASE_CLK,
  output logic [NUM_DOM-1:0] RELEASE_ISO,
  output logic [NUM_DOM-1:0] RELEASE_RST,
  output logic [NUM_DOM-1:0] DOM_RUN,
  output logic               BUSY,
  output logic [NUM_DOM-1:0] OVR_STATE
);

  localparam logic HOLD = `IO_HOLD;
  localparam logic REL  = `IO_RELEASE;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_UP_PWR = 3'd1,
    S_UP_CLK = 3'd2,
    S_UP_ISO = 3'd3,
    S_RUN    = 3'd4,
    S_DN_RST = 3'd5,
    S_DN_ISO = 3'd6,
    S_DN_CLK = 3'd7
  } st_t;

  logic [NUM_DOM-1:0] ovr;
  logic [NUM_DOM-1:0] busy_vec;

  // Sticky override bits: once the bus claims a domain it keeps it until reset.
  always_ff @(posedge CLK_EXT or negedge RESETn_local) begin
    if (!RESETn_local) ovr <= '0;
    else               ovr <= ovr | BUS_PWR_OVERRIDE;
  end

  assign OVR_STATE = ovr;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    st_t              st, st_nxt;
    logic [DLY_W-1:0] cnt, cnt_nxt;
    // ctl bit order: {rst, iso, clk, pwr}; registered so each control moves cleanly on its own edge.
    logic [3:0]       ctl, ctl_nxt;
    logic             step_done;

    // State, step counter and control registers on the falling edge.
    always_ff @(negedge CLK_EXT or negedge RESETn_local) begin
      if (!RESETn_local) begin
        st  <= S_OFF;
        cnt <= '0;
        ctl <= {4{HOLD}};
      end else begin
        st  <= st_nxt;
        cnt <= cnt_nxt;
        ctl <= ctl_nxt;
      end
    end

    // Next state: requests only matter in OFF/RUN; transient states advance once the step delay expires.
    always_comb begin
      st_nxt    = st;
      cnt_nxt   = cnt;
      step_done = (cnt == '0);
      case (st)
        S_OFF:    if (WAKEUP_REQ[g])                   st_nxt = S_UP_PWR;
        S_UP_PWR: if (step_done)                       st_nxt = S_UP_CLK;
        S_UP_CLK: if (step_done)                       st_nxt = S_UP_ISO;
        S_UP_ISO: if (step_done)                       st_nxt = S_RUN;
        S_RUN:    if (SLEEP_REQ[g] && !WAKEUP_REQ[g])  st_nxt = S_DN_RST;
        S_DN_RST: if (step_done)                       st_nxt = S_DN_ISO;
        S_DN_ISO: if (step_done)                       st_nxt = S_DN_CLK;
        S_DN_CLK: if (step_done)                       st_nxt = S_OFF;
        default:                                       st_nxt = S_OFF;
      endcase
      // STEP_DLY is captured only when a new step begins; mid-step changes wait for the next step.
      if (st_nxt != st) begin
        cnt_nxt = (st_nxt == S_OFF || st_nxt == S_RUN) ? '0 : STEP_DLY;
      end else if (!step_done) begin
        cnt_nxt = cnt - DLY_W'(1);
      end
    end

    // Control levels for the state being entered.
    always_comb begin
      ctl_nxt = {4{HOLD}};
      case (st_nxt)
        S_OFF:    ctl_nxt = {HOLD, HOLD, HOLD, HOLD};
        S_UP_PWR: ctl_nxt = {HOLD, HOLD, HOLD, REL };
        S_UP_CLK: ctl_nxt = {HOLD, HOLD, REL,  REL };
        S_UP_ISO: ctl_nxt = {HOLD, REL,  REL,  REL };
        S_RUN:    ctl_nxt = {REL,  REL,  REL,  REL };
        S_DN_RST: ctl_nxt = {HOLD, REL,  REL,  REL };
        S_DN_ISO: ctl_nxt = {HOLD, HOLD, REL,  REL };
        S_DN_CLK: ctl_nxt = {HOLD, HOLD, HOLD, REL };
        default:  ctl_nxt = {4{HOLD}};
      endcase
    end

    assign POWER_ON[g]    = ovr[g] ? POWER_ON_FROM_BUS[g]    : ctl[0];
    assign RELEASE_CLK[g] = ovr[g] ? RELEASE_CLK_FROM_BUS[g] : ctl[1];
    assign RELEASE_ISO[g] = ovr[g] ? RELEASE_ISO_FROM_BUS[g] : ctl[2];
    assign RELEASE_RST[g] = ovr[g] ? RELEASE_RST_FROM_BUS[g] : ctl[3];
    assign DOM_RUN[g]     = (st == S_RUN);
    assign busy_vec[g]    = (st != S_OFF) && (st != S_RUN);
  end

  assign BUSY = |busy_vec;

endmodule

// File: doc/mbus_pwr_seq_multi.md
Name: mbus_pwr_seq_multi

Overview:
- Parametrised multi-domain power sequencer for MBus layer controllers; generalises the single-domain processor wake-up sequence.
- Drives N independent power domains with a full power-up and reverse power-down sequence, using a programmable inter-step delay.
- Provides a per-domain sticky bus-override mux that hands domain control to the MBus node's power outputs.
- Sits between the bus controller wrapper, the sleep controller and the layer power switches.

Parameters:
NUM_DOM, 2, number of independent power domains (1..8)
DLY_W, 4, width of inter-step delay counter and STEP_DLY input

Ports:
CLK_EXT  input  1  sequencer clock; sequence FSMs on negedge, override latches on posedge
RESETn_local  input  1  asynchronous active-low reset
STEP_DLY  input  DLY_W  extra wait cycles between sequence steps (0 = one step per cycle)
WAKEUP_REQ  input  NUM_DOM  level request: bring domain i to RUN
SLEEP_REQ  input  NUM_DOM  level request: bring domain i to OFF
BUS_PWR_OVERRIDE  input  NUM_DOM  pulse/level: hand domain i to bus-side controls (sticky)
POWER_ON_FROM_BUS  input  NUM_DOM  bus-side power-on per domain
RELEASE_CLK_FROM_BUS  input  NUM_DOM  bus-side clock release per domain
RELEASE_ISO_FROM_BUS  input  NUM_DOM  bus-side isolation release per domain
RELEASE_RST_FROM_BUS  input  NUM_DOM  bus-side reset release per domain
POWER_ON  output  NUM_DOM  muxed power-on to domain
RELEASE_CLK  output  NUM_DOM  muxed clock release
RELEASE_ISO  output  NUM_DOM  muxed isolation release
RELEASE_RST  output  NUM_DOM  muxed reset release
DOM_RUN  output  NUM_DOM  domain i internal FSM in RUN
BUSY  output  1  OR of all domains not in OFF or RUN
OVR_STATE  output  NUM_DOM  current sticky override bits

Behaviour:
- Encoding: all four control outputs use `IO_HOLD`/`IO_RELEASE` from mbus_def.
- Reset (async, RESETn_local low):
  - All internal controls go to IO_HOLD; FSMs go to OFF; delay counters clear; override bits clear.
  - Hence POWER_ON, RELEASE_CLK, RELEASE_ISO and RELEASE_RST = IO_HOLD; DOM_RUN = 0; BUSY = 0; OVR_STATE = 0.
  - Reset mid-sequence aborts immediately. There is no graceful power-down.
- Per-domain FSM (negedge CLK_EXT), one independent instance per domain.
  - Up path: OFF -> UP_PWR -> UP_CLK -> UP_ISO -> RUN. Entering each state releases respectively power, clock, iso and reset.
  - Down path: RUN -> DN_RST -> DN_ISO -> DN_CLK -> OFF. Entering each state holds respectively reset, iso, clock and power.
  - Entry into OFF holds power.
- Step timing:
  - On entering any transient state, the counter loads STEP_DLY.
  - The FSM advances when the counter = 0; otherwise it decrements.
  - With STEP_DLY = 0, the outputs change on four consecutive negedges. With STEP_DLY = d, they are spaced d+1 cycles apart.
  - STEP_DLY is sampled at each load only; changes mid-step take effect at the next step.
- Triggers:
  - OFF leaves on WAKEUP_REQ=1.
  - RUN leaves on SLEEP_REQ=1 & WAKEUP_REQ=0. Wake wins in RUN, so the domain stays up.
  - In OFF, both high -> power up.
  - Requests are ignored in transient states. A sequence always completes to OFF or RUN, then the levels are re-evaluated.
  - Example: WAKEUP dropped and SLEEP raised during up-sequence -> reaches RUN, then starts the down-sequence on the next negedge.
- Override (posedge CLK_EXT):
  - OVR_STATE[i] sets when BUS_PWR_OVERRIDE[i]=1 and is cleared only by reset.
  - When set, the four outputs for domain i pass the *_FROM_BUS[i] inputs combinationally.
  - The internal FSM keeps running but is not visible; DOM_RUN still reflects the internal FSM.
- BUSY: combinational OR across domains of (state ∉ {OFF, RUN}).
- Domains share no state except the STEP_DLY input and BUSY.

Test Plan:
- Reset release, NUM_DOM=2, STEP_DLY=0, WAKEUP_REQ=2'b01 -> domain 0 releases POWER_ON, RELEASE_CLK, RELEASE_ISO and RELEASE_RST on 4 consecutive negedges. DOM_RUN=01 after the 4th; domain 1 stays all IO_HOLD.
- STEP_DLY=3, domain 1 in RUN, SLEEP_REQ[1]=1 -> reset, iso, clock and power held in order, spaced 4 cycles apart. BUSY high from the first negedge through the OFF entry.
- Domain 0 mid-up (UP_CLK), WAKEUP_REQ=0 and SLEEP_REQ=1 -> the up-sequence completes to RUN, then the down-sequence completes to OFF. No output glitches out of order.
- WAKEUP_REQ=SLEEP_REQ=1 from OFF -> reaches RUN and stays there while both remain high.
- Pulse BUS_PWR_OVERRIDE[1] for one cycle, then toggle RELEASE_ISO_FROM_BUS[1] -> OVR_STATE=10 persists and RELEASE_ISO[1] follows the bus input. Domain 0 is unaffected.
- Assert RESETn_local low during a down-sequence with STEP_DLY=5 -> all outputs = IO_HOLD immediately (asynchronous); OVR_STATE=0 and BUSY=0.
